tour_cmd: RTL
=============

# tour_cmd

Reader and translator for the knight-tour solver's move list. After the solver reports a completed tour, this block walks move indices 0..23, decodes each one-hot move into two movement commands (vertical leg, then horizontal leg) and issues them to the command processor through a ready/clear/response handshake. When no tour is active, the block passes UART commands straight through to the command processor.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse from solver `done`; begins playback
- move  in  8  one-hot move addressed by mv_indx (solver readout, combinational)
- mv_indx  out  5  index of move being played; drives solver `indx`
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy  in  1  pulse from command processor: command accepted
- send_resp  in  1  pulse from command processor: command executed
- cmd  out  16  command to command processor
- cmd_rdy  out  1  command valid to command processor
- clr_cmd_rdy_UART  out  1  accept pulse forwarded to UART wrapper
- send_resp_UART  out  1  execution pulse forwarded to UART wrapper
- tour_err  out  1  one-cycle pulse: illegal move encoding found, playback aborted

## Operation
- Decided: reset rst_n, asynchronous, active-low; clock clk.
- Move decode (dx,dy): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1). +y is north, +x is east.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares. Move opcode 4'b0010. Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF. squares = |d| (1 or 2).
- Vertical leg: heading is north if dy>0, else south. Horizontal leg: heading is east if dx>0, else west.
- FSM states: IDLE, VERT, VHOLD, HORZ, HHOLD.
  - IDLE: mux is transparent (cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, send_resp_UART=send_resp). On start_tour: mv_indx<=0, go to VERT.
  - VERT: cmd is the vertical leg and cmd_rdy=1. If move is not one-hot (including zero), pulse tour_err and go to IDLE. On clr_cmd_rdy, go to VHOLD.
  - VHOLD: cmd_rdy=0, cmd held. On send_resp, go to HORZ.
  - HORZ: cmd is the horizontal leg and cmd_rdy=1. On clr_cmd_rdy, go to HHOLD.
  - HHOLD: cmd_rdy=0. On send_resp: if mv_indx==23, pulse send_resp_UART and go to IDLE; otherwise mv_indx<=mv_indx+1 and go to VERT.
- Outside IDLE: clr_cmd_rdy_UART=0 and send_resp_UART=0 (except the final tour response); cmd_UART and cmd_rdy_UART are ignored; a UART command remains pending until the tour ends.
- start_tour outside IDLE is ignored.
- send_resp in VERT or HORZ is ignored. clr_cmd_rdy in a HOLD state is ignored.

## Timing
- Reset: state IDLE, mv_indx=0, tour_err=0. Because IDLE is transparent, cmd/cmd_rdy/clr_cmd_rdy_UART/send_resp_UART follow the UART/processor inputs (cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, ...).
- cmd and cmd_rdy are combinational from the state, the registered mv_indx and the move input. cmd_rdy rises 1 cycle after start_tour.
- cmd_rdy deasserts the cycle after clr_cmd_rdy is sampled.
- Every leg requires at least 2 cycles plus the command processor's latency.
- tour_err asserts in the cycle move is sampled in VERT; the block is in IDLE on the next cycle.
- Final send_resp_UART is combinational with the last send_resp in HHOLD (same cycle).
- rst_n asserted mid-tour returns the block to IDLE immediately. No partial state survives.

## Configuration
- TOUR_CMD_FANFARE_EN defined: the horizontal leg uses opcode 4'b0011 (move with fanfare), so each completed knight move plays fanfare. The vertical leg stays 4'b0010.
- Not defined: both legs use 4'b0010.

## Test plan
- Reset then idle passthrough: cmd_UART=16'h2005 with cmd_rdy_UART=1 -> cmd=16'h2005 and cmd_rdy=1. clr_cmd_rdy pulse -> clr_cmd_rdy_UART pulse in the same cycle.
- start_tour with move[0]=8'h01 -> cmd=16'h2002 (north 2). After clr/resp -> cmd=16'h2BF1 (east 1 is wrong, since dx=-1): required cmd=16'h23F1 (west 1), or 16'h33F1 with TOUR_CMD_FANFARE_EN.
- Full 24-move model tour with auto-responding processor -> 48 commands issued in index order, exactly one send_resp_UART pulse at the end, then state IDLE.
- move=8'h00 at index 5 -> tour_err pulse, cmd_rdy low, passthrough restored, mv_indx stays 5.
- send_resp during VERT, plus start_tour mid-tour -> both ignored: no index advance, no restart.
- rst_n low during HHOLD of index 10 -> IDLE with mv_indx=0. A new start_tour replays from index 0.

Source files
------------

// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tour_cmd
//  Purpose  : Knight-tour move-list player. After the solver finishes, walks
//             move indices 0..23, splits each one-hot knight move into a
//             vertical leg and a horizontal leg, and hands both to the command
//             processor via the cmd_rdy / clr_cmd_rdy / send_resp handshake.
//             With no tour active the UART command path passes straight
//             through to the command processor.
//  Options  : TOUR_CMD_FANFARE_EN - horizontal leg uses the move-with-fanfare
//             opcode so every completed knight move plays fanfare.
//  Revision : 1.0 - initial release
// ============================================================================
module tour_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  output logic        send_resp_UART,
  output logic        tour_err
);

  localparam logic [3:0] c_OP_VERT = 4'b0010;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] c_OP_HORZ = 4'b0011;
`else
  localparam logic [3:0] c_OP_HORZ = 4'b0010;
`endif
  localparam logic [7:0] c_HDG_NORTH = 8'h00;
  localparam logic [7:0] c_HDG_WEST  = 8'h3F;
  localparam logic [7:0] c_HDG_SOUTH = 8'h7F;
  localparam logic [7:0] c_HDG_EAST  = 8'hBF;
  localparam logic [4:0] c_LAST_IDX  = 5'd23;

  // Move bit groups. Bit order: 0(-1,+2) 1(+1,+2) 2(-2,+1) 3(-2,-1)
  // 4(-1,-2) 5(+1,-2) 6(+2,-1) 7(+2,+1)
  localparam logic [7:0] c_MSK_NORTH = 8'b1000_0111;  // dy > 0
  localparam logic [7:0] c_MSK_DY2   = 8'b0011_0011;  // |dy| == 2
  localparam logic [7:0] c_MSK_EAST  = 8'b1110_0010;  // dx > 0
  localparam logic [7:0] c_MSK_DX2   = 8'b1100_1100;  // |dx| == 2

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    VHOLD = 3'd2,
    HORZ  = 3'd3,
    HHOLD = 3'd4
  } state_t;

  state_t      r_state;
  logic [4:0]  r_mv_indx;

  logic        w_onehot;
  logic        w_last;
  logic [15:0] w_vert_cmd;
  logic [15:0] w_horz_cmd;

  assign mv_indx = r_mv_indx;
  assign w_last  = (r_mv_indx == c_LAST_IDX);

  // Exactly one bit set; zero is illegal as well
  assign w_onehot = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

  assign w_vert_cmd = {c_OP_VERT,
                       (|(move & c_MSK_NORTH)) ? c_HDG_NORTH : c_HDG_SOUTH,
                       (|(move & c_MSK_DY2))   ? 4'd2 : 4'd1};
  assign w_horz_cmd = {c_OP_HORZ,
                       (|(move & c_MSK_EAST))  ? c_HDG_EAST : c_HDG_WEST,
                       (|(move & c_MSK_DX2))   ? 4'd2 : 4'd1};

  // Playback sequencer: index register and leg/handshake phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_mv_indx <= 5'd0;
            r_state   <= VERT;
          end
        end
        VERT: begin
          // A corrupt move aborts the tour before it is ever accepted
          if (!w_onehot)
            r_state <= IDLE;
          else if (clr_cmd_rdy)
            r_state <= VHOLD;
        end
        VHOLD: begin
          if (send_resp)
            r_state <= HORZ;
        end
        HORZ: begin
          if (clr_cmd_rdy)
            r_state <= HHOLD;
        end
        HHOLD: begin
          if (send_resp) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 5'd1;
              r_state   <= VERT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command mux: UART passthrough when idle, decoded legs during a tour
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    send_resp_UART   = 1'b0;
    tour_err         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        send_resp_UART   = send_resp;
      end
      VERT: begin
        cmd      = w_vert_cmd;
        // Never offer a command decoded from an illegal move
        cmd_rdy  = w_onehot;
        tour_err = ~w_onehot;
      end
      VHOLD: begin
        cmd = w_vert_cmd;
      end
      HORZ: begin
        cmd     = w_horz_cmd;
        cmd_rdy = 1'b1;
      end
      HHOLD: begin
        cmd = w_horz_cmd;
        // The UART side sees one response for the whole tour
        send_resp_UART = send_resp & w_last;
      end
      default: begin
        cmd = cmd_UART;
      end
    endcase
  end

endmodule
`default_nettype wire
